// File: rtl/cpu_defs_pkg.sv
// Shared decode definitions: opcodes, FSM states,
// and the ID/EX bundle passed to execute.
package cpu_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    SQUASH
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        link_we;
    logic [31:0] link_data;
  } id_ex_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational control-flow decode, compare and targets.
// Ports: if_pc/if_ir/rs_data/rt_data in; taken flags, targets out.
module branch_target_calc (
  input  logic [31:0] if_pc,
  input  logic [31:0] if_ir,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        is_jump,
  output logic        is_branch,
  output logic        is_jal,
  output logic [31:0] jump_addr,
  output logic [31:0] branch_addr
);
  import cpu_defs_pkg::*;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [31:0] boff;
  logic        eq;

  assign op   = if_ir[31:26];
  assign fn   = if_ir[5:0];
  assign boff = {{14{if_ir[15]}}, if_ir[15:0], 2'b00};
  assign eq   = (rs_data == rt_data);

  // if_pc already points past the branch.
  assign branch_addr = if_pc + boff;

  always_comb begin
    is_jump   = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    jump_addr = {if_pc[31:28], if_ir[25:0], 2'b00};
    unique case (1'b1)
      op == OP_BEQ: is_branch = eq;
      op == OP_BNE: is_branch = !eq;
      op == OP_J:   is_jump = 1'b1;
      op == OP_JAL: begin
        is_jump = 1'b1;
        is_jal  = 1'b1;
      end
      (op == OP_RTYPE) && (fn == FUNCT_JR): begin
        is_jump   = 1'b1;
        jump_addr = rs_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve_decode.sv
// Decode stage: resolves redirects, squashes wrong path, feeds ID/EX.
// Ports: fetch PC/IR + RF data in; redirects, ID/EX regs, counters out.
module branch_resolve_decode #(
  parameter bit DELAY_SLOT = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_ir,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic             jump,
  output logic             branch,
  output logic [31:0]      jump_addr,
  output logic [31:0]      branch_addr,
  output logic             ex_valid,
  output logic [31:0]      ex_ir,
  output logic [31:0]      ex_pc,
  output logic             ex_link_we,
  output logic [31:0]      ex_link_data,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] squash_cnt
);
  import cpu_defs_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state;
  state_t state_nxt;
  logic   id_valid;
  logic   redirect;
  logic   is_jump;
  logic   is_branch;
  logic   is_jal;
  id_ex_t ex_q;
  id_ex_t ex_d;

  assign rs_addr = if_ir[25:21];
  assign rt_addr = if_ir[20:16];

  branch_target_calc u_calc (
    .if_pc       (if_pc),
    .if_ir       (if_ir),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .is_jump     (is_jump),
    .is_branch   (is_branch),
    .is_jal      (is_jal),
    .jump_addr   (jump_addr),
    .branch_addr (branch_addr)
  );

  assign id_valid = (state == RUN);
  assign jump     = rst & id_valid & is_jump;
  assign branch   = rst & id_valid & is_branch;
  assign redirect = jump | branch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= state_nxt;
  end

  // Fetch has already issued one sequential instruction
  // past a redirect; SQUASH drops it unless it is a slot.
  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (!DELAY_SLOT && redirect) state_nxt = SQUASH;
      SQUASH:  state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    ex_d.valid     = id_valid;
    ex_d.ir        = id_valid ? if_ir : NOP;
    ex_d.pc        = if_pc - 32'd4;
    ex_d.link_we   = id_valid & is_jal;
    ex_d.link_data = if_pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q         <= '0;
      redirect_cnt <= '0;
      squash_cnt   <= '0;
    end else begin
      ex_q <= ex_d;
      if (redirect && redirect_cnt != CNT_MAX)
        redirect_cnt <= redirect_cnt + CNT_ONE;
      if (state == SQUASH && squash_cnt != CNT_MAX)
        squash_cnt <= squash_cnt + CNT_ONE;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_ir        = ex_q.ir;
  assign ex_pc        = ex_q.pc;
  assign ex_link_we   = ex_q.link_we;
  assign ex_link_data = ex_q.link_data;

endmodule
